// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: sequences the PS/2 byte receiver, folds E0/F0 prefixes into
// single key events, queues them in a small FIFO and routes protocol replies
// (ACK, RESEND, BAT result, overrun) to sticky status flags.
module ps2_kbd_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          ps2_clk_i,
    input  logic          rst,
    input  logic          enable,
    output logic          rx_en,
    input  logic          rx_busy,
    input  logic          rx_done,
    input  logic [7:0]    rx_data,
    input  logic          rx_err,
    input  logic          ev_pop,
    output logic          ev_valid,
    output logic [9:0]    ev_data,
    output logic [AW:0]   ev_count,
    output logic          overflow,
    output logic          ack_seen,
    output logic          resend_req,
    output logic          bat_ok,
    output logic          bat_fail,
    output logic [7:0]    err_cnt,
    input  logic          clr_status
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [9:0]    mem_q [DEPTH];
    logic [9:0]    ev_data_q, ev_data_d;
    logic          rx_en_q;
    logic          overflow_q, ack_q, resend_q, bat_ok_q, bat_fail_q;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          push;
    logic [9:0]    push_data;
    logic          err_inc;
    logic          set_ack, set_resend, set_bat_ok, set_bat_fail;
    logic          full, empty, do_pop, do_push, drop;
    logic [AW-1:0] head_idx;

    // Byte decode: prefix folding, special replies and error handling
    always_comb begin
        state_d      = state_q;
        push         = 1'b0;
        push_data    = '0;
        err_inc      = 1'b0;
        set_ack      = 1'b0;
        set_resend   = 1'b0;
        set_bat_ok   = 1'b0;
        set_bat_fail = 1'b0;
        if (rx_done && enable) begin
            if (rx_err) begin
                err_inc = 1'b1;
                state_d = IDLE;
            end else begin
                case (rx_data)
                    8'hFA: set_ack      = 1'b1;
                    8'hFE: set_resend   = 1'b1;
                    8'hAA: set_bat_ok   = 1'b1;
                    8'hFC: set_bat_fail = 1'b1;
                    8'h00, 8'hFF: err_inc = 1'b1;
                    8'hE0: begin
                        if (state_q == IDLE) begin
                            state_d = EXT;
                        end else begin
                            state_d = IDLE;
                            err_inc = 1'b1;
                        end
                    end
                    8'hF0: begin
                        if (state_q == IDLE) begin
                            state_d = BRK;
                        end else if (state_q == EXT) begin
                            state_d = EXT_BRK;
                        end else begin
                            state_d = IDLE;
                            err_inc = 1'b1;
                        end
                    end
                    default: begin
                        push      = 1'b1;
                        push_data = {(state_q == EXT) || (state_q == EXT_BRK),
                                     (state_q == BRK) || (state_q == EXT_BRK),
                                     rx_data};
                        state_d   = IDLE;
                    end
                endcase
            end
        end
    end

    // FIFO bookkeeping and next head; a push into an empty queue becomes the head directly
    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_pop   = ev_pop && !empty;
        do_push  = push && (!full || do_pop);
        drop     = push && full && !do_pop;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        head_idx = rd_ptr_d[AW-1:0];
        if (wr_ptr_d == rd_ptr_d) begin
            ev_data_d = '0;
        end else if (do_push && (head_idx == wr_ptr_q[AW-1:0])) begin
            ev_data_d = push_data;
        end else begin
            ev_data_d = mem_q[head_idx];
        end
        if (clr_status) begin
            err_cnt_d = '0;
        end else if (err_inc && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Event storage; contents need no reset because the pointers define validity
    always_ff @(posedge ps2_clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    // Prefix FSM, FIFO pointers, registered head, receiver enable and status
    always_ff @(posedge ps2_clk_i) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ev_data_q  <= '0;
            rx_en_q    <= 1'b0;
            overflow_q <= 1'b0;
            ack_q      <= 1'b0;
            resend_q   <= 1'b0;
            bat_ok_q   <= 1'b0;
            bat_fail_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ev_data_q  <= ev_data_d;
            rx_en_q    <= rx_busy || (enable && !full);
            overflow_q <= !clr_status && (overflow_q || drop);
            ack_q      <= !clr_status && (ack_q || set_ack);
            resend_q   <= !clr_status && (resend_q || set_resend);
            bat_ok_q   <= !clr_status && (bat_ok_q || set_bat_ok);
            bat_fail_q <= !clr_status && (bat_fail_q || set_bat_fail);
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign rx_en      = rx_en_q;
    assign ev_valid   = (wr_ptr_q != rd_ptr_q);
    assign ev_data    = ev_data_q;
    assign ev_count   = wr_ptr_q - rd_ptr_q;
    assign overflow   = overflow_q;
    assign ack_seen   = ack_q;
    assign resend_req = resend_q;
    assign bat_ok     = bat_ok_q;
    assign bat_fail   = bat_fail_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// tb_ps2_kbd_ctrl: table-driven vectors plus hand-written corner sequences,
// with a queue of expected events compared as the DUT presents its head.
module tb_ps2_kbd_ctrl;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          ps2_clk_i;
    logic          rst;
    logic          enable;
    logic          rx_en;
    logic          rx_busy;
    logic          rx_done;
    logic [7:0]    rx_data;
    logic          rx_err;
    logic          ev_pop;
    logic          ev_valid;
    logic [9:0]    ev_data;
    logic [AW:0]   ev_count;
    logic          overflow;
    logic          ack_seen;
    logic          resend_req;
    logic          bat_ok;
    logic          bat_fail;
    logic [7:0]    err_cnt;
    logic          clr_status;

    int testsRun;
    int testsFailed;
    logic [9:0] sb[$];

    typedef struct {
        logic [7:0] data;
        logic       err;
        logic       emit;
        logic [9:0] ev;
    } vec_t;

    vec_t vecs[12];

    ps2_kbd_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
        .ps2_clk_i (ps2_clk_i),
        .rst       (rst),
        .enable    (enable),
        .rx_en     (rx_en),
        .rx_busy   (rx_busy),
        .rx_done   (rx_done),
        .rx_data   (rx_data),
        .rx_err    (rx_err),
        .ev_pop    (ev_pop),
        .ev_valid  (ev_valid),
        .ev_data   (ev_data),
        .ev_count  (ev_count),
        .overflow  (overflow),
        .ack_seen  (ack_seen),
        .resend_req(resend_req),
        .bat_ok    (bat_ok),
        .bat_fail  (bat_fail),
        .err_cnt   (err_cnt),
        .clr_status(clr_status)
    );

    // Free-running PS/2-side clock
    initial begin
        ps2_clk_i = 1'b0;
        forever #5 ps2_clk_i = ~ps2_clk_i;
    end

    // Hard stop in case anything hangs
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
        end
    endtask

    // One clock edge with the given strobes asserted, then back to idle 1 ns later
    task automatic applyStimulus(input logic done, input logic [7:0] data, input logic err,
                                 input logic pop, input logic clr);
        rx_done    = done;
        rx_data    = data;
        rx_err     = err;
        ev_pop     = pop;
        clr_status = clr;
        @(posedge ps2_clk_i);
        #1;
        rx_done    = 1'b0;
        rx_err     = 1'b0;
        ev_pop     = 1'b0;
        clr_status = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] data);
        applyStimulus(1'b1, data, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkFlags(input string name, input logic [4:0] flags, input logic [7:0] cnt);
        checkOutput({name, "_flags"}, {27'd0, overflow, ack_seen, resend_req, bat_ok, bat_fail},
                    {27'd0, flags});
        checkOutput({name, "_err_cnt"}, {24'd0, err_cnt}, {24'd0, cnt});
    endtask

    // Pop every queued event, comparing each head against the expected queue
    task automatic drainAndCheck(input string name);
        for (int g = 0; g < DEPTH + 4; g++) begin
            if (!ev_valid) break;
            if (sb.size() == 0) begin
                checkOutput({name, "_extra_event"}, {31'd0, ev_valid}, 32'd0);
            end else begin
                checkOutput({name, "_head"}, {22'd0, ev_data}, {22'd0, sb.pop_front()});
            end
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        checkOutput({name, "_count_end"}, {28'd0, ev_count}, sb.size());
        checkOutput({name, "_valid_end"}, {31'd0, ev_valid}, 32'd0);
        checkOutput({name, "_data_end"}, {22'd0, ev_data}, 32'd0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        rst        = 1'b0;
        enable     = 1'b1;
        rx_busy    = 1'b0;
        rx_done    = 1'b0;
        rx_data    = 8'h00;
        rx_err     = 1'b0;
        ev_pop     = 1'b0;
        clr_status = 1'b0;

        vecs[0]  = '{8'h1C, 1'b0, 1'b1, 10'h01C};
        vecs[1]  = '{8'hE0, 1'b0, 1'b0, 10'h000};
        vecs[2]  = '{8'hF0, 1'b0, 1'b0, 10'h000};
        vecs[3]  = '{8'h74, 1'b0, 1'b1, 10'h374};
        vecs[4]  = '{8'hF0, 1'b0, 1'b0, 10'h000};
        vecs[5]  = '{8'h1C, 1'b0, 1'b1, 10'h11C};
        vecs[6]  = '{8'hE0, 1'b0, 1'b0, 10'h000};
        vecs[7]  = '{8'h12, 1'b1, 1'b0, 10'h000};
        vecs[8]  = '{8'h1C, 1'b0, 1'b1, 10'h01C};
        vecs[9]  = '{8'hE0, 1'b0, 1'b0, 10'h000};
        vecs[10] = '{8'hFA, 1'b0, 1'b0, 10'h000};
        vecs[11] = '{8'h6B, 1'b0, 1'b1, 10'h26B};

        // Reset state
        idleCycle();
        idleCycle();
        checkOutput("reset_rx_en", {31'd0, rx_en}, 32'd0);
        checkOutput("reset_valid", {31'd0, ev_valid}, 32'd0);
        checkOutput("reset_data", {22'd0, ev_data}, 32'd0);
        checkOutput("reset_count", {28'd0, ev_count}, 32'd0);
        checkFlags("reset", 5'b00000, 8'd0);
        rst = 1'b1;
        idleCycle();
        checkOutput("rx_en_after_reset", {31'd0, rx_en}, 32'd1);

        // Table-driven prefix folding
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b1, vecs[i].data, vecs[i].err, 1'b0, 1'b0);
            if (vecs[i].emit) sb.push_back(vecs[i].ev);
            checkOutput($sformatf("vec%0d_count", i), {28'd0, ev_count}, sb.size());
            checkOutput($sformatf("vec%0d_valid", i), {31'd0, ev_valid}, {31'd0, sb.size() != 0});
            if (sb.size() != 0)
                checkOutput($sformatf("vec%0d_head", i), {22'd0, ev_data}, {22'd0, sb[0]});
        end
        checkFlags("vectors", 5'b01000, 8'd1);
        drainAndCheck("vectors_drain");

        // Pop when empty is ignored
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOutput("empty_pop_count", {28'd0, ev_count}, 32'd0);
        checkOutput("empty_pop_valid", {31'd0, ev_valid}, 32'd0);

        // Fill, overflow, rx_en throttling and push+pop while full
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            sendByte(8'h10 + 8'(i));
            sb.push_back({2'b00, 8'h10 + 8'(i)});
        end
        checkOutput("full_count", {28'd0, ev_count}, DEPTH);
        checkOutput("full_rx_en_lag", {31'd0, rx_en}, 32'd1);
        idleCycle();
        checkOutput("full_rx_en", {31'd0, rx_en}, 32'd0);
        sendByte(8'h18);
        checkOutput("ovf_flag", {31'd0, overflow}, 32'd1);
        checkOutput("ovf_count", {28'd0, ev_count}, DEPTH);
        checkOutput("ovf_head", {22'd0, ev_data}, {22'd0, sb[0]});
        rx_busy = 1'b1;
        idleCycle();
        checkOutput("busy_rx_en", {31'd0, rx_en}, 32'd1);
        rx_busy = 1'b0;
        idleCycle();
        checkOutput("unbusy_rx_en", {31'd0, rx_en}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOutput("ovf_cleared", {31'd0, overflow}, 32'd0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
        void'(sb.pop_front());
        sb.push_back(10'h055);
        checkOutput("pushpop_count", {28'd0, ev_count}, DEPTH);
        checkOutput("pushpop_ovf", {31'd0, overflow}, 32'd0);
        checkOutput("pushpop_head", {22'd0, ev_data}, 32'h011);
        drainAndCheck("full_drain");

        // Protocol replies and overrun bytes
        sendByte(8'hFA);
        sendByte(8'hAA);
        sendByte(8'hFE);
        sendByte(8'hFC);
        sendByte(8'h00);
        checkFlags("special", 5'b01111, 8'd1);
        checkOutput("special_count", {28'd0, ev_count}, 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        checkFlags("clr", 5'b00000, 8'd0);
        applyStimulus(1'b1, 8'hFA, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        checkFlags("clr_wins", 5'b00000, 8'd0);

        // err_cnt saturation
        for (int i = 0; i < 300; i++) sendByte(8'hFF);
        checkOutput("err_cnt_sat", {24'd0, err_cnt}, 32'hFF);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Disabled controller ignores bytes and drops rx_en
        enable = 1'b0;
        sendByte(8'h1C);
        checkOutput("disabled_count", {28'd0, ev_count}, 32'd0);
        checkOutput("disabled_rx_en", {31'd0, rx_en}, 32'd0);
        enable = 1'b1;
        idleCycle();

        // Reset mid-sequence flushes queue, prefix and status
        sendByte(8'h21);
        sendByte(8'h22);
        sendByte(8'h23);
        sendByte(8'hFA);
        sendByte(8'h00);
        sendByte(8'hE0);
        checkOutput("pre_reset_count", {28'd0, ev_count}, 32'd3);
        rst = 1'b0;
        idleCycle();
        checkOutput("midreset_valid", {31'd0, ev_valid}, 32'd0);
        checkOutput("midreset_data", {22'd0, ev_data}, 32'd0);
        checkOutput("midreset_count", {28'd0, ev_count}, 32'd0);
        checkOutput("midreset_rx_en", {31'd0, rx_en}, 32'd0);
        checkFlags("midreset", 5'b00000, 8'd0);
        rst = 1'b1;
        sb.delete();
        idleCycle();
        sendByte(8'h1C);
        sb.push_back(10'h01C);
        checkOutput("post_reset_head", {22'd0, ev_data}, 32'h01C);
        drainAndCheck("post_reset_drain");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
